// File: rtl/piso_stream.sv
// ============================================================================
// piso_stream : parallel-to-serial converter with a one-word holding buffer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_stream #(
   parameter int   WIDTH     = 4,
   parameter bit   LSB_FIRST = 1'b1,
   parameter logic IDLE_VAL  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_last,
   output logic             empty
);

   localparam int                 c_cnt_w    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic               ser_valid_q, ser_valid_d;
   logic               hold_valid_q, hold_valid_d;

   logic [WIDTH-1:0]   w_shift_adv;
   logic               w_head_bit;
   logic               w_accept;
   logic               w_last;
   logic               w_xfer;
   logic               w_done;
   logic               w_load_slot;

   generate
      if (LSB_FIRST) begin : g_lsb_first
         assign w_shift_adv = {1'b0, shift_q[WIDTH-1:1]};
         assign w_head_bit  = shift_q[0];
      end else begin : g_msb_first
         assign w_shift_adv = {shift_q[WIDTH-2:0], 1'b0};
         assign w_head_bit  = shift_q[WIDTH-1];
      end
   endgenerate

   assign w_accept    = in_valid & in_ready;
   assign w_last      = ser_valid_q & (cnt_q == c_last_cnt);
   assign w_xfer      = ser_valid_q & ser_ready;
   assign w_done      = w_xfer & w_last;
   // The shifter may take a new word when idle or on the edge its last bit leaves.
   assign w_load_slot = ~ser_valid_q | w_done;

   always_comb begin
      shift_d      = shift_q;
      hold_d       = hold_q;
      cnt_d        = cnt_q;
      ser_valid_d  = ser_valid_q;
      hold_valid_d = hold_valid_q;

      if (w_xfer && !w_last) begin
         shift_d = w_shift_adv;
         cnt_d   = cnt_q + c_cnt_w'(1);
      end

      if (w_load_slot) begin
         if (hold_valid_q) begin
            shift_d      = hold_q;
            cnt_d        = '0;
            ser_valid_d  = 1'b1;
            hold_valid_d = w_accept;
            if (w_accept) begin
               hold_d = in_data;
            end
         end else if (w_accept) begin
            shift_d     = in_data;
            cnt_d       = '0;
            ser_valid_d = 1'b1;
         end else if (w_done) begin
            shift_d     = w_shift_adv;
            cnt_d       = '0;
            ser_valid_d = 1'b0;
         end
      end else if (w_accept) begin
         hold_d       = in_data;
         hold_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q      <= '0;
         hold_q       <= '0;
         cnt_q        <= '0;
         ser_valid_q  <= 1'b0;
         hold_valid_q <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         cnt_q        <= cnt_d;
         ser_valid_q  <= ser_valid_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   assign in_ready  = rst & ~hold_valid_q;
   assign ser_valid = ser_valid_q;
   assign ser_out   = ser_valid_q ? w_head_bit : IDLE_VAL;
   assign ser_last  = w_last;
   assign empty     = ~ser_valid_q & ~hold_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_piso_stream.sv
// ============================================================================
// tb_piso_stream : bit-queue reference model plus directed and random traffic
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_stream;

   typedef struct packed {
      logic b;
      logic l;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] a_in_data;
   logic       a_in_valid, a_in_ready, a_ser_out, a_ser_valid, a_ser_ready, a_ser_last, a_empty;
   logic [7:0] b_in_data;
   logic       b_in_valid, b_in_ready, b_ser_out, b_ser_valid, b_ser_ready, b_ser_last, b_empty;

   int  n_checks = 0;
   int  n_pass   = 0;
   int  cyc      = 0;
   sb_t qa[$];
   sb_t qb[$];
   logic reca[$];
   int   reca_cyc[$];
   logic recb[$];

   int   sa, sb;
   bit   xa, aa, xb, ab;
   int   wi, guard;
   bit   rdy, saw_busy;
   logic [3:0] words [3];

   piso_stream #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_VAL(1'b0)) u_dut_a (
      .clk(clk), .rst(rst_n), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .ser_out(a_ser_out), .ser_valid(a_ser_valid), .ser_ready(a_ser_ready),
      .ser_last(a_ser_last), .empty(a_empty));

   piso_stream #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_VAL(1'b1)) u_dut_b (
      .clk(clk), .rst(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .ser_out(b_ser_out), .ser_valid(b_ser_valid), .ser_ready(b_ser_ready),
      .ser_last(b_ser_last), .empty(b_empty));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] pack_a();
      logic [31:0] v = '0;
      for (int k = 0; k < reca.size() && k < 32; k++) v[k] = reca[k];
      return v;
   endfunction

   function automatic logic [31:0] pack_b();
      logic [31:0] v = '0;
      for (int k = 0; k < recb.size() && k < 32; k++) v[k] = recb[k];
      return v;
   endfunction

   // Model: each block is a FIFO of pending bits; hold is occupied when more than one word is pending.
   always @(posedge clk) begin
      cyc++;
      if (a_ser_valid && a_ser_ready) begin
         reca.push_back(a_ser_out);
         reca_cyc.push_back(cyc);
      end
      if (b_ser_valid && b_ser_ready) recb.push_back(b_ser_out);
      if (rst_n) begin
         sa = qa.size();
         xa = (sa > 0) && a_ser_ready;
         aa = a_in_valid && (sa <= 4);
         if (xa) void'(qa.pop_front());
         if (aa) for (int k = 0; k < 4; k++) qa.push_back(sb_t'{a_in_data[k], k == 3});
         sb = qb.size();
         xb = (sb > 0) && b_ser_ready;
         ab = b_in_valid && (sb <= 8);
         if (xb) void'(qb.pop_front());
         if (ab) for (int k = 0; k < 8; k++) qb.push_back(sb_t'{b_in_data[7-k], k == 7});
      end
   end

   always @(negedge rst_n) begin
      qa.delete();
      qb.delete();
   end

   always @(negedge clk) begin
      chk("a_ser_valid", a_ser_valid, qa.size() > 0);
      chk("a_ser_out",   a_ser_out,   (qa.size() > 0) ? qa[0].b : 1'b0);
      chk("a_ser_last",  a_ser_last,  (qa.size() > 0) ? qa[0].l : 1'b0);
      chk("a_in_ready",  a_in_ready,  rst_n && (qa.size() <= 4));
      chk("a_empty",     a_empty,     qa.size() == 0);
      chk("b_ser_valid", b_ser_valid, qb.size() > 0);
      chk("b_ser_out",   b_ser_out,   (qb.size() > 0) ? qb[0].b : 1'b1);
      chk("b_ser_last",  b_ser_last,  (qb.size() > 0) ? qb[0].l : 1'b0);
      chk("b_in_ready",  b_in_ready,  rst_n && (qb.size() <= 8));
      chk("b_empty",     b_empty,     qb.size() == 0);
   end

   initial begin
      rst_n = 1'b0;
      a_in_data = '0; a_in_valid = 1'b0; a_ser_ready = 1'b1;
      b_in_data = '0; b_in_valid = 1'b0; b_ser_ready = 1'b1;
      repeat (3) tick();
      chk("rst_a_in_ready", a_in_ready, 0);
      chk("rst_a_empty", a_empty, 1);
      chk("rst_b_ser_out_idle", b_ser_out, 1);
      rst_n = 1'b1;
      tick();
      chk("post_rst_a_in_ready", a_in_ready, 1);

      // single word 1011, LSB first
      reca.delete();
      a_in_data = 4'b1011; a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("s1_ser_last", a_ser_last, k == 3);
         tick();
      end
      chk("s1_idle_valid", a_ser_valid, 0);
      chk("s1_idle_out", a_ser_out, 0);
      chk("s1_idle_empty", a_empty, 1);
      chk("s1_len", reca.size(), 4);
      chk("s1_bits", pack_a(), 32'hB);

      // back-to-back words 0xA, 0x5, 0xF
      reca.delete(); reca_cyc.delete();
      words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hF;
      wi = 0; guard = 0; saw_busy = 1'b0;
      a_in_valid = 1'b1;
      while (wi < 3 && guard < 40) begin
         a_in_data = words[wi];
         rdy = a_in_ready;
         if (!rdy) saw_busy = 1'b1;
         tick();
         if (rdy) wi++;
         guard++;
      end
      a_in_valid = 1'b0;
      chk("s2_words_accepted", wi, 3);
      chk("s2_saw_in_ready_low", saw_busy, 1);
      repeat (16) tick();
      chk("s2_len", reca.size(), 12);
      chk("s2_bits", pack_a(), 32'hF5A);
      chk("s2_no_gap", (reca_cyc.size() == 12) ? reca_cyc[11] - reca_cyc[0] : -1, 11);

      // backpressure on 0x6 after its second bit
      reca.delete();
      a_in_data = 4'h6; a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      tick(); tick();
      a_ser_ready = 1'b0;
      repeat (3) begin
         chk("s3_stall_out", a_ser_out, 1);
         chk("s3_stall_last", a_ser_last, 0);
         chk("s3_stall_valid", a_ser_valid, 1);
         tick();
      end
      a_ser_ready = 1'b1;
      repeat (4) tick();
      chk("s3_len", reca.size(), 4);
      chk("s3_bits", pack_a(), 32'h6);

      // 8-bit MSB-first, idle level 1
      chk("s4_idle_before", b_ser_out, 1);
      recb.delete();
      b_in_data = 8'h96; b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      repeat (8) tick();
      chk("s4_idle_after", b_ser_out, 1);
      chk("s4_valid_after", b_ser_valid, 0);
      chk("s4_len", recb.size(), 8);
      chk("s4_bits", pack_b(), 32'h69);

      // reset mid-word with a word held
      a_in_data = 4'hC; a_in_valid = 1'b1;
      tick();
      a_in_data = 4'h3;
      tick();
      a_in_valid = 1'b0;
      tick();
      chk("s5_hold_full", a_in_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("s5_rst_valid", a_ser_valid, 0);
      chk("s5_rst_out", a_ser_out, 0);
      chk("s5_rst_last", a_ser_last, 0);
      chk("s5_rst_empty", a_empty, 1);
      chk("s5_rst_in_ready", a_in_ready, 0);
      tick(); tick();
      rst_n = 1'b1;
      reca.delete();
      tick();
      a_in_data = 4'h9; a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      repeat (6) tick();
      chk("s5_len", reca.size(), 4);
      chk("s5_bits", pack_a(), 32'h9);

      // new word presented exactly as the last bit leaves
      reca.delete(); reca_cyc.delete();
      a_in_data = 4'h3; a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      repeat (3) tick();
      a_in_data = 4'h5; a_in_valid = 1'b1;
      chk("s6_last_now", a_ser_last, 1);
      chk("s6_ready_now", a_in_ready, 1);
      tick();
      a_in_valid = 1'b0;
      chk("s6_next_valid", a_ser_valid, 1);
      chk("s6_next_first", a_ser_out, 1);
      chk("s6_next_last", a_ser_last, 0);
      chk("s6_hold_unused", a_in_ready, 1);
      repeat (5) tick();
      chk("s6_len", reca.size(), 8);
      chk("s6_bits", pack_a(), 32'h53);
      chk("s6_no_gap", (reca_cyc.size() == 8) ? reca_cyc[7] - reca_cyc[0] : -1, 7);

      // random traffic on both instances
      for (int n = 0; n < 600; n++) begin
         a_in_valid  = 1'($urandom_range(0, 1));
         a_in_data   = 4'($urandom);
         a_ser_ready = ($urandom_range(0, 3) != 0);
         b_in_valid  = 1'($urandom_range(0, 1));
         b_in_data   = 8'($urandom);
         b_ser_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      a_in_valid = 1'b0; b_in_valid = 1'b0;
      a_ser_ready = 1'b1; b_ser_ready = 1'b1;
      repeat (20) tick();
      chk("drain_a_empty", a_empty, 1);
      chk("drain_b_empty", b_empty, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-to-serial converter with ready/valid handshakes on both sides.
- Accepts WIDTH-bit words and shifts them out one bit per accepted transfer.
- A one-word holding buffer lets consecutive words stream with zero bubble cycles.
- Successor to the fixed 4-bit serializer: adds configurable width, bit order and idle level, downstream backpressure, a last-bit marker and an input handshake.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 is transmitted first; 0 = bit WIDTH-1 is transmitted first.
- IDLE_VAL, 0, value driven on ser_out while ser_valid=0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- in_data  input  WIDTH  parallel word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a valid bit.
- ser_ready  input  1  downstream accepts ser_out this cycle.
- ser_last  output  1  current bit is the final bit of its word.
- empty  output  1  no word held anywhere in the block.

Behaviour:
- Storage:
  - Shift register plus bit counter (active word), counter width max(1,$clog2(WIDTH)).
  - Hold register with a hold_valid flag.
- Reset: rst low clears all state asynchronously.
  - Shift register = 0, counter = 0, hold_valid = 0, ser_valid = 0.
  - ser_out = IDLE_VAL, ser_last = 0, empty = 1.
  - in_ready = 0 while rst is low.
  - Reset mid-word discards the partial word and any held word, with no further serial output.
- Handshakes:
  - in_ready = rst & ~hold_valid. An input word is accepted when in_valid & in_ready at a clk edge.
  - A bit transfers when ser_valid & ser_ready at a clk edge.
  - ser_valid & ~ser_ready stalls the output: ser_out, ser_last, counter and shift register stay stable.
- ser_out, ser_valid and ser_last come from registered state only. There is no combinational path from in_data or in_valid to the serial outputs.
- Bit order:
  - LSB_FIRST=1: ser_out = shift[0]; shift right by one per transfer.
  - LSB_FIRST=0: ser_out = shift[WIDTH-1]; shift left by one per transfer.
  - Vacated bits fill with 0.
- ser_last = ser_valid & (counter == WIDTH-1).
- Word completes ("done") when a transfer occurs with ser_last = 1.
- Shifter load priority at each edge, evaluated only when the shifter is idle (ser_valid=0) or done:
  - a) hold_valid=1 -> load hold register, clear hold_valid, counter=0, ser_valid=1.
  - b) else an input word is accepted -> load in_data directly, counter=0, ser_valid=1.
  - c) else, if done -> ser_valid=0, ser_out=IDLE_VAL.
- When the shifter is busy and not done, an accepted input word goes to the hold register and sets hold_valid.
- Simultaneous done and input accept with hold_valid=1:
  - held word moves into the shifter;
  - new word enters the hold register;
  - hold_valid stays 1.
  - This case cannot arise because in_ready=0 whenever hold_valid=1; it is listed for completeness.
- Latency: a word accepted at edge N into an idle block drives its first bit at cycle N+1.
  - With ser_ready held high, the word occupies cycles N+1..N+WIDTH.
  - The next word's first bit follows on cycle N+WIDTH+1 with no gap.
- empty = ~ser_valid & ~hold_valid.

Test Plan:
- WIDTH=4, LSB_FIRST=1, ser_ready=1; send 4'b1011 at edge N -> ser_out = 1,1,0,1 on cycles N+1..N+4; ser_last only on N+4; ser_valid=0, ser_out=IDLE_VAL and empty=1 from N+5.
- WIDTH=4; in_valid held high with words 0xA, 0x5, 0xF -> 12 consecutive valid bits 0,1,0,1,1,0,1,0,1,1,1,1 with no gap; in_ready low while the hold register is full; ser_last every 4th bit.
- WIDTH=4, word 0x6; drop ser_ready for 3 cycles after the 2nd bit -> ser_out holds 1 and ser_last stays 0 for those cycles; the remaining bits 1,0 follow once ser_ready returns.
- WIDTH=8, LSB_FIRST=0, IDLE_VAL=1; send 0x96 -> ser_out = 1,0,0,1,0,1,1,0; ser_out=1 while idle before and after the word.
- Assert rst low after the 2nd bit of 0xC with 0x3 held -> all outputs at reset values immediately; in_ready=0 during reset. After release, 0x9 produces 1,0,0,1 only, with no leftover bits from 0xC or 0x3.
- Hold empty; present a new word on the exact cycle the last bit of the current word transfers -> the new word's first bit appears on the next cycle, with zero bubble and no hold-register use.
